// File: rtl/demux_1bit_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshakes. Each output
// channel has a one-entry holding register and a delivered-word counter.
module demux_1bit_reg #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     input_data,
    input  logic                 input_valid,
    input  logic                 select,
    output logic                 input_ready,
    output logic [WIDTH-1:0]     output_data0,
    output logic                 output_valid0,
    input  logic                 output_ready0,
    output logic [WIDTH-1:0]     output_data1,
    output logic                 output_valid1,
    input  logic                 output_ready1,
    output logic [CNT_WIDTH-1:0] count0,
    output logic [CNT_WIDTH-1:0] count1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_e;

    ch_state_e            state0_q, state0_d;
    ch_state_e            state1_q, state1_d;
    logic [WIDTH-1:0]     data0_q, data0_d;
    logic [WIDTH-1:0]     data1_q, data1_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

    logic free0, free1;
    logic acc0, acc1;
    logic del0, del1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state0_q <= EMPTY;
            state1_q <= EMPTY;
            data0_q  <= '0;
            data1_q  <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state0_q <= state0_d;
            state1_q <= state1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    always_comb begin
        // A FULL channel that is draining this cycle can take a new word.
        free0       = (state0_q == EMPTY) | output_ready0;
        free1       = (state1_q == EMPTY) | output_ready1;
        input_ready = select ? free1 : free0;

        acc0 = input_valid & input_ready & ~select;
        acc1 = input_valid & input_ready &  select;
        del0 = (state0_q == FULL) & output_ready0;
        del1 = (state1_q == FULL) & output_ready1;

        state0_d = state0_q;
        state1_d = state1_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;

        if (acc0) begin
            state0_d = FULL;
            data0_d  = input_data;
        end else if (del0) begin
            state0_d = EMPTY;
        end

        if (acc1) begin
            state1_d = FULL;
            data1_d  = input_data;
        end else if (del1) begin
            state1_d = EMPTY;
        end

        if (del0) cnt0_d = cnt0_q + CNT_WIDTH'(1);
        if (del1) cnt1_d = cnt1_q + CNT_WIDTH'(1);
    end

    assign output_data0  = data0_q;
    assign output_data1  = data1_q;
    assign output_valid0 = (state0_q == FULL);
    assign output_valid1 = (state1_q == FULL);
    assign count0        = cnt0_q;
    assign count1        = cnt1_q;

endmodule

// File: tb/tb_demux_1bit_reg.sv
// Bench for demux_1bit_reg: directed scenarios followed by random traffic,
// checked against a queue-based model of the two holding registers.
module tb_demux_1bit_reg;

    logic        clk;
    logic        reset;
    logic [31:0] input_data;
    logic        input_valid;
    logic        select;
    logic        input_ready;
    logic [31:0] output_data0;
    logic        output_valid0;
    logic        output_ready0;
    logic [31:0] output_data1;
    logic        output_valid1;
    logic        output_ready1;
    logic [7:0]  count0;
    logic [7:0]  count1;

    demux_1bit_reg #(
        .WIDTH     (32),
        .CNT_WIDTH (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .input_data    (input_data),
        .input_valid   (input_valid),
        .select        (select),
        .input_ready   (input_ready),
        .output_data0  (output_data0),
        .output_valid0 (output_valid0),
        .output_ready0 (output_ready0),
        .output_data1  (output_data1),
        .output_valid1 (output_valid1),
        .output_ready1 (output_ready1),
        .count0        (count0),
        .count1        (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: each channel is a queue holding at most one word.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] last0, last1;
    int          n0, n1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        n0    = 0;
        n1    = 0;
    endtask

    task automatic check_outputs();
        logic exp_rdy;
        exp_rdy = select ? (q1.size() == 0 || output_ready1)
                         : (q0.size() == 0 || output_ready0);
        chk("input_ready", 32'(input_ready), 32'(exp_rdy));
        chk("valid0", 32'(output_valid0), 32'(q0.size() != 0));
        chk("valid1", 32'(output_valid1), 32'(q1.size() != 0));
        chk("data0", output_data0, last0);
        chk("data1", output_data1, last1);
        chk("count0", 32'(count0), 32'(n0 % 256));
        chk("count1", 32'(count1), 32'(n1 % 256));
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input logic v, input logic s, input logic [31:0] d,
                        input logic r0, input logic r1);
        logic del0, del1, acc;
        input_valid   = v;
        select        = s;
        input_data    = d;
        output_ready0 = r0;
        output_ready1 = r1;
        #1;
        check_outputs();
        del0 = (q0.size() != 0) && r0;
        del1 = (q1.size() != 0) && r1;
        acc  = v && (s ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0));
        @(posedge clk);
        if (del0) begin void'(q0.pop_front()); n0++; end
        if (del1) begin void'(q1.pop_front()); n1++; end
        if (acc) begin
            if (s) begin q1.push_back(d); last1 = d; end
            else   begin q0.push_back(d); last0 = d; end
        end
        @(negedge clk);
    endtask

    int c1_before;

    initial begin
        reset         = 1'b1;
        input_data    = '0;
        input_valid   = 1'b0;
        select        = 1'b0;
        output_ready0 = 1'b0;
        output_ready1 = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state, then fill channel 0 and reset mid-cycle.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0);
        chk("pre_reset_valid0", 32'(output_valid0), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_valid0", 32'(output_valid0), 32'd0);
        chk("async_count0", 32'(count0), 32'd0);
        chk("async_data0", output_data0, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Basic route to channel 0 with latency of one edge.
        step(1'b1, 1'b0, 32'hFFFF0000, 1'b0, 1'b0);
        #1;
        chk("route_data0", output_data0, 32'hFFFF0000);
        chk("route_valid0", 32'(output_valid0), 32'd1);
        chk("route_valid1", 32'(output_valid1), 32'd0);

        // Back-pressure on channel 0, then switch the same word to channel 1.
        input_valid   = 1'b1;
        select        = 1'b0;
        input_data    = 32'h0000FFFF;
        output_ready0 = 1'b0;
        #1;
        chk("bp_ready_sel0", 32'(input_ready), 32'd0);
        step(1'b1, 1'b1, 32'h0000FFFF, 1'b0, 1'b0);
        #1;
        chk("bp_data0_hold", output_data0, 32'hFFFF0000);
        chk("bp_data1", output_data1, 32'h0000FFFF);

        // Full throughput on channel 1.
        c1_before = int'(count1);
        step(1'b1, 1'b1, 32'h88888888, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'hFEFEFEFE, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
        chk("thru_count1", 32'(count1), 32'((c1_before + 3) % 256));

        // Deliver on channel 0 while accepting on channel 1.
        step(1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
        #1;
        chk("simul_valid0", 32'(output_valid0), 32'd0);
        chk("simul_data1", output_data1, 32'hA5A5A5A5);

        // Counter wrap on channel 0 after a clean reset.
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 1'b0, $urandom, 1'b1, 1'b0);
            if (n0 == 255) chk("wrap_255", 32'(count0), 32'd255);
            if (n0 == 256) chk("wrap_0", 32'(count0), 32'd0);
        end
        chk("wrap_count1", 32'(count1), 32'd0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 $urandom, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
